// File: rtl/pcie_wr_gen.sv
// pcie_wr_gen: DMA memory-write TLP generator.
// Takes a descriptor (host address, TLP count) and cuts payload from an FWFT
// FIFO into fixed NQW-qword MWr TLPs. Each TLP goes to the TX arbiter as
// NQW+2 beats of {1dw, last, qword}. A TLP only starts once its whole
// payload is buffered, because a beat is never stalled by the FIFO.
module pcie_wr_gen #(
  parameter int NQW = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] pcie_id,
  input  logic        desc_valid,
  output logic        desc_ready,
  input  logic [63:0] desc_addr,
  input  logic [15:0] desc_count,
  input  logic [63:0] i_data,
  input  logic        i_valid,
  input  logic [11:0] i_count,
  output logic        i_read,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [65:0] wr_data0,
  output logic        busy,
  output logic        done,
  output logic        underflow
);

  localparam int              BW        = $clog2(NQW + 2);
  localparam logic [BW-1:0]   B_ONE     = BW'(1);
  localparam logic [BW-1:0]   B_TWO     = BW'(2);
  localparam logic [BW-1:0]   B_NQW     = BW'(NQW);
  localparam logic [BW-1:0]   B_LAST    = BW'(NQW + 1);
  localparam logic [63:0]     STEP      = 64'(NQW * 8);
  localparam logic [63:0]     ADDR_MASK = ~(STEP - 64'd1);
  localparam logic [31:0]     LEN_DW    = 32'(2 * NQW);
  localparam logic [11:0]     FULL_CNT  = 12'(NQW);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND} state_t;

  state_t         state_q;
  logic [63:0]    addr_q;
  logic [15:0]    count_q;
  logic [BW-1:0]  b_q;
  logic [31:0]    hold_q;
  logic           is4_q;
  logic           desc_ready_q;
  logic           done_q;
  logic           underflow_q;

  logic           pop_beat;
  logic [31:0]    dw0;
  logic [31:0]    dw1;

  assign desc_ready = desc_ready_q;
  assign done       = done_q;
  assign underflow  = underflow_q;
  assign wr_valid   = (state_q == S_SEND);
  assign busy       = (state_q != S_IDLE);

  assign dw0 = (is4_q ? 32'h6000_0000 : 32'h4000_0000) | LEN_DW;
  assign dw1 = {pcie_id, 8'h00, 8'hFF};

  // Payload beats: 4DW pops on b2..b(NQW+1); 3DW is one beat earlier since
  // DW0 of the payload rides alongside the 32-bit address in b1.
  always_comb begin
    pop_beat = is4_q ? (b_q >= B_TWO) : ((b_q >= B_ONE) && (b_q <= B_NQW));
    i_read   = (state_q == S_SEND) && wr_ready && pop_beat;
  end

  // Beat mux: header, address, then payload (shifted by one DW for 3DW).
  always_comb begin
    wr_data0 = '0;
    if (state_q == S_SEND) begin
      if (b_q == '0) begin
        wr_data0 = {2'b00, dw1, dw0};
      end else if (is4_q) begin
        if (b_q == B_ONE) wr_data0 = {2'b00, addr_q[31:0], addr_q[63:32]};
        else              wr_data0 = {1'b0, (b_q == B_LAST), i_data};
      end else begin
        if (b_q == B_ONE)       wr_data0 = {2'b00, i_data[31:0], addr_q[31:0]};
        else if (b_q == B_LAST) wr_data0 = {2'b11, 32'h0, hold_q};
        else                    wr_data0 = {2'b00, i_data[31:0], hold_q};
      end
    end
  end

  // Control FSM plus descriptor, beat counter and DW carry registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      count_q      <= '0;
      b_q          <= '0;
      hold_q       <= '0;
      is4_q        <= 1'b0;
      desc_ready_q <= 1'b0;
      done_q       <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (i_read) hold_q <= i_data[63:32];
      if (i_read && !i_valid) underflow_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          desc_ready_q <= 1'b1;
          if (desc_valid && desc_ready_q) begin
            desc_ready_q <= 1'b0;
            addr_q       <= desc_addr & ADDR_MASK;
            count_q      <= desc_count;
            if (desc_count == 16'd0) done_q  <= 1'b1;
            else                     state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_count >= FULL_CNT) begin
            state_q <= S_SEND;
            b_q     <= '0;
            is4_q   <= |addr_q[63:32];
          end
        end
        S_SEND: begin
          if (wr_ready) begin
            if (b_q == B_LAST) begin
              b_q     <= '0;
              addr_q  <= addr_q + STEP;
              count_q <= count_q - 16'd1;
              if (count_q == 16'd1) begin
                state_q      <= S_IDLE;
                done_q       <= 1'b1;
                desc_ready_q <= 1'b1;
              end else begin
                state_q <= S_WAIT;
              end
            end else begin
              b_q <= b_q + B_ONE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_wr_gen.sv
// Bench for pcie_wr_gen: FIFO model, expected-beat scoreboard and a monitor
// that checks every consumed beat and the inter-TLP gap.
module tb_pcie_wr_gen;
  localparam int NQW = 16;
  localparam logic [15:0] ID = 16'hBEEF;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        desc_valid = 1'b0;
  logic        desc_ready;
  logic [63:0] desc_addr = '0;
  logic [15:0] desc_count = '0;
  logic [63:0] i_data;
  logic        i_valid;
  logic [11:0] i_count;
  logic        i_read;
  logic        wr_valid;
  logic        wr_ready = 1'b1;
  logic [65:0] wr_data0;
  logic        busy, done, underflow;

  pcie_wr_gen #(.NQW(NQW)) dut (
    .clock(clock), .reset(reset), .pcie_id(ID),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_addr(desc_addr), .desc_count(desc_count),
    .i_data(i_data), .i_valid(i_valid), .i_count(i_count), .i_read(i_read),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data0(wr_data0),
    .busy(busy), .done(done), .underflow(underflow)
  );

  always #5 clock = ~clock;

  // FWFT FIFO model
  logic [63:0] mem [256];
  logic [7:0]  wr_ptr = 8'd0;
  logic [7:0]  rd_ptr = 8'd0;
  logic [7:0]  occ;
  assign occ     = wr_ptr - rd_ptr;
  assign i_valid = (occ != 8'd0);
  assign i_data  = mem[rd_ptr];
  assign i_count = {4'b0, occ};
  always @(posedge clock) if (i_read && i_valid) rd_ptr <= rd_ptr + 8'd1;

  logic [65:0] exp_q [$];
  logic [65:0] cap [NQW+2];
  int checks = 0, errors = 0, beats = 0, done_cnt = 0, beats_at_done = 0;
  int cap_idx = 0;
  bit last_seen = 0;
  bit rdy_alt = 0;

  function automatic logic [63:0] qd(input int k);
    return {k[31:0], k[31:0]};
  endfunction

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic fill(input int base, input int n);
    for (int k = 0; k < n; k++) begin
      mem[wr_ptr] = qd(base + k);
      wr_ptr = wr_ptr + 8'd1;
    end
  endtask

  // Expected beats of one TLP carrying qwords base..base+NQW-1
  task automatic push_tlp(input logic [63:0] addr, input int base);
    logic        is4;
    logic [63:0] q, qp;
    is4 = (addr[63:32] != 32'h0);
    exp_q.push_back({2'b00, ID, 8'h00, 8'hFF,
                     (is4 ? 32'h6000_0000 : 32'h4000_0000) | 32'(2 * NQW)});
    if (is4) begin
      exp_q.push_back({2'b00, addr[31:0], addr[63:32]});
      for (int j = 0; j < NQW; j++)
        exp_q.push_back({1'b0, (j == NQW - 1), qd(base + j)});
    end else begin
      q = qd(base);
      exp_q.push_back({2'b00, q[31:0], addr[31:0]});
      for (int j = 1; j < NQW; j++) begin
        q  = qd(base + j);
        qp = qd(base + j - 1);
        exp_q.push_back({2'b00, q[31:0], qp[63:32]});
      end
      q = qd(base + NQW - 1);
      exp_q.push_back({2'b11, 32'h0, q[63:32]});
    end
  endtask

  // Offer a descriptor and return once it has been accepted
  task automatic send_desc(input logic [63:0] addr, input logic [15:0] cnt);
    bit ok;
    ok = 0;
    desc_valid = 1'b1; desc_addr = addr; desc_count = cnt;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (desc_ready) ok = 1;
      @(posedge clock); #1;
    end
    desc_valid = 1'b0;
    if (!ok) begin checks++; errors++; $display("FAIL desc_accept timeout"); end
  endtask

  task automatic wait_done(input int d0, input int bound);
    bit ok;
    ok = 0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(posedge clock); #1;
      if (done_cnt > d0) ok = 1;
    end
    if (!ok) begin checks++; errors++; $display("FAIL done timeout"); end
  endtask

  task automatic run_desc(input logic [63:0] addr, input logic [15:0] cnt, input string nm);
    int d0;
    d0 = done_cnt;
    send_desc(addr, cnt);
    wait_done(d0, 600);
    repeat (3) @(posedge clock);
    #1;
    chk({nm, "_done_once"}, 66'(done_cnt), 66'(d0 + 1));
    chk({nm, "_exp_empty"}, 66'(exp_q.size()), 66'd0);
  endtask

  // wr_ready driver: always 1, or alternating to exercise arbiter stalls
  initial forever begin
    @(posedge clock); #1;
    wr_ready = rdy_alt ? ~wr_ready : 1'b1;
  end

  // Monitor: compare every consumed beat against the scoreboard
  initial begin
    logic [65:0] e;
    forever begin
      @(negedge clock);
      if (reset) begin
        last_seen = 0; cap_idx = 0;
      end else begin
        if (done) begin done_cnt++; beats_at_done = beats; end
        if (last_seen) begin
          checks++;
          if (wr_valid !== 1'b0) begin
            errors++; $display("FAIL tlp_gap wr_valid=%b want 0", wr_valid);
          end
        end
        last_seen = 0;
        if (wr_valid && wr_ready) begin
          cap[cap_idx] = wr_data0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL beat_unexpected got %h want none", wr_data0);
          end else begin
            e = exp_q.pop_front();
            if (wr_data0 !== e) begin
              errors++; $display("FAIL beat%0d got %h want %h", beats, wr_data0, e);
            end
          end
          beats++;
          if (wr_data0[64]) begin last_seen = 1; cap_idx = 0; end
          else if (cap_idx < NQW + 1) cap_idx++;
        end
      end
    end
  end

  initial begin
    int b0, d0;
    bit ok, bad;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_outs", 66'({desc_ready, wr_valid, i_read, busy, done, underflow}), 66'd0);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("idle_ready", 66'({desc_ready, busy}), 66'b10);

    // 4DW single TLP with a stalling arbiter
    rdy_alt = 1;
    fill(0, NQW);
    push_tlp(64'h1_2345_6780, 0);
    run_desc(64'h1_2345_6780, 16'd1, "t4dw");
    chk("t4dw_b0", cap[0], {2'b00, 32'hBEEF00FF, 32'h60000020});
    chk("t4dw_b1", cap[1], {2'b00, 32'h23456780, 32'h00000001});
    chk("t4dw_b17", cap[17], {2'b01, 32'h0000000F, 32'h0000000F});

    // 3DW single TLP
    fill(0, NQW);
    push_tlp(64'h8000_0000, 0);
    run_desc(64'h8000_0000, 16'd1, "t3dw");
    chk("t3dw_b0", cap[0], {2'b00, 32'hBEEF00FF, 32'h40000020});
    chk("t3dw_b1", cap[1], {2'b00, 32'h00000000, 32'h80000000});
    chk("t3dw_b2", cap[2], {2'b00, 32'h00000001, 32'h00000000});
    chk("t3dw_b17", cap[17], {2'b11, 32'h00000000, 32'h0000000F});
    chk("t3dw_pops", 66'(occ), 66'd0);

    // Three TLPs crossing 4 GiB, arbiter always ready
    rdy_alt = 0;
    fill(0, 3 * NQW);
    push_tlp(64'h0_FFFF_FF00, 0);
    push_tlp(64'h0_FFFF_FF80, NQW);
    push_tlp(64'h1_0000_0000, 2 * NQW);
    b0 = beats;
    run_desc(64'h0_FFFF_FF00, 16'd3, "tmulti");
    chk("tmulti_beats_at_done", 66'(beats_at_done - b0), 66'd54);

    // Starvation: 15 qwords must not start a TLP
    fill(0, NQW - 1);
    push_tlp(64'h2000, 0);
    d0 = done_cnt;
    send_desc(64'h2000, 16'd1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (wr_valid || i_read) bad = 1;
      @(posedge clock); #1;
    end
    chk("starve_quiet", 66'(bad), 66'd0);
    fill(NQW - 1, 1);
    ok = 0;
    for (int i = 0; i < 2 && !ok; i++) begin
      @(posedge clock); #1;
      if (wr_valid) ok = 1;
    end
    chk("starve_release", 66'(ok), 66'd1);
    wait_done(d0, 200);

    // count=0 followed immediately by count=1
    repeat (2) @(posedge clock);
    #1;
    d0 = done_cnt; b0 = beats;
    desc_valid = 1'b1; desc_addr = 64'h3000; desc_count = 16'd0;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (desc_ready) ok = 1;
      @(posedge clock); #1;
    end
    desc_count = 16'd1;
    chk("cnt0_pulse", 66'({ok, done, desc_ready, wr_valid}), 66'b1100);
    fill(0, NQW);
    push_tlp(64'h3000, 0);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (desc_ready) ok = 1;
      @(posedge clock); #1;
    end
    desc_valid = 1'b0;
    chk("b2b_accept", 66'({ok, busy, desc_ready}), 66'b110);
    wait_done(d0 + 1, 200);
    repeat (3) @(posedge clock);
    #1;
    chk("b2b_dones", 66'(done_cnt), 66'(d0 + 2));
    chk("b2b_beats", 66'(beats - b0), 66'd18);

    // Reset at b7 of a 4DW TLP
    fill(0, NQW);
    push_tlp(64'h1_0000_0000, 0);
    b0 = beats;
    send_desc(64'h1_0000_0000, 16'd1);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (beats == b0 + 7) ok = 1;
      else begin @(posedge clock); #1; end
    end
    chk("rst_reach_b7", 66'(ok), 66'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("rst_mid_outs", 66'({wr_valid, busy, desc_ready}), 66'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    exp_q.delete();
    wr_ptr = rd_ptr;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_release_ready", 66'({desc_ready, busy}), 66'b10);
    fill(0, NQW);
    push_tlp(64'h1_2345_6780, 0);
    b0 = beats;
    run_desc(64'h1_2345_6780, 16'd1, "trst");
    chk("trst_beats", 66'(beats - b0), 66'd18);

    chk("underflow", 66'(underflow), 66'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
endmodule
